// File: rtl/draw_sprite_engine.sv
// Rectangle renderer: walks a SPRITE_W x SPRITE_H area row-major, either from a sprite ROM
// (with colour-key transparency) or as a solid fill, emitting one clipped VGA write per pixel.
module draw_sprite_engine #(
   parameter int SPRITE_W  = 16,
   parameter int SPRITE_H  = 16,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOR_W   = 3,
   parameter int ROM_LAT   = 1,
   parameter int KEY_COLOR = 0,
   parameter int ADDR_W    = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               mode,
   input  logic [X_W-1:0]     x_in,
   input  logic [Y_W-1:0]     y_in,
   input  logic [COLOR_W-1:0] fill_colour,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_data,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [COLOR_W-1:0] vga_colour,
   output logic               plot,
   output logic               busy,
   output logic               done
);

   localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   localparam logic [COL_W-1:0]   LAST_COL = COL_W'(SPRITE_W - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(SPRITE_H - 1);
   localparam logic [X_W:0]       SCR_W_PX = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]       SCR_H_PY = (Y_W + 1)'(SCREEN_H);
   localparam logic [COLOR_W-1:0] KEY_C    = COLOR_W'(KEY_COLOR);
   localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(ROM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [X_W-1:0]     r_xLat;
   logic [Y_W-1:0]     r_yLat;
   logic               r_modeLat;
   logic [COLOR_W-1:0] r_fillLat;
   logic [LAT_W-1:0]   r_latCnt;
   logic [X_W-1:0]     r_lastX;
   logic [Y_W-1:0]     r_lastY;

   logic               w_lastCol;
   logic               w_lastPix;
   logic               w_inWrite;
   logic [X_W:0]       w_px;
   logic [Y_W:0]       w_py;
   logic               w_visible;

   assign w_lastCol = (r_col == LAST_COL);
   assign w_lastPix = w_lastCol && (r_row == LAST_ROW);
   assign w_inWrite = (r_state == S_WRITE);

   // One extra bit on the screen coordinates keeps off-screen pixels from wrapping back on-screen.
   assign w_px = (X_W + 1)'(r_xLat) + (X_W + 1)'(r_col);
   assign w_py = (Y_W + 1)'(r_yLat) + (Y_W + 1)'(r_row);
   assign w_visible = (w_px < SCR_W_PX) && (w_py < SCR_H_PY) && (r_modeLat || (rom_data != KEY_C));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_stateNext = mode ? S_WRITE : S_FETCH;
            end
         end
         S_FETCH: begin
            w_stateNext = (ROM_LAT > 1) ? S_WAIT : S_WRITE;
         end
         S_WAIT: begin
            if (r_latCnt == LAT_W'(1)) begin
               w_stateNext = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_lastPix) begin
               w_stateNext = S_DONE;
            end else if (r_modeLat) begin
               w_stateNext = S_WRITE;
            end else begin
               w_stateNext = S_FETCH;
            end
         end
         S_DONE: begin
            w_stateNext = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // The latency counter loads in FETCH so WAIT lasts exactly ROM_LAT-1 cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col     <= '0;
         r_row     <= '0;
         r_xLat    <= '0;
         r_yLat    <= '0;
         r_modeLat <= 1'b0;
         r_fillLat <= '0;
         r_latCnt  <= '0;
         r_lastX   <= '0;
         r_lastY   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_xLat    <= x_in;
                  r_yLat    <= y_in;
                  r_modeLat <= mode;
                  r_fillLat <= fill_colour;
                  r_col     <= '0;
                  r_row     <= '0;
               end
            end
            S_FETCH: begin
               r_latCnt <= LAT_LOAD;
            end
            S_WAIT: begin
               r_latCnt <= r_latCnt - LAT_W'(1);
            end
            S_WRITE: begin
               r_lastX <= w_px[X_W-1:0];
               r_lastY <= w_py[Y_W-1:0];
               if (w_lastCol) begin
                  r_col <= '0;
                  r_row <= w_lastPix ? '0 : r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rom_addr   = ADDR_W'(r_row) * ADDR_W'(SPRITE_W) + ADDR_W'(r_col);
   assign vga_x      = w_inWrite ? w_px[X_W-1:0] : r_lastX;
   assign vga_y      = w_inWrite ? w_py[Y_W-1:0] : r_lastY;
   assign vga_colour = !w_inWrite ? '0 : (r_modeLat ? r_fillLat : rom_data);
   assign plot       = w_inWrite && w_visible;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_draw_sprite_engine.sv
// Scoreboard bench for draw_sprite_engine: a ROM_LAT=1 and a ROM_LAT=3 instance are driven with
// directed and random draws; a pixel-level model predicts every plot (position, colour, cycle) and done.
module tb_draw_sprite_engine;

   localparam int SW    = 16;
   localparam int SH    = 16;
   localparam int NPIX  = SW * SH;
   localparam int LAT0  = 1;
   localparam int LAT1  = 3;
   localparam int SCRW  = 160;
   localparam int SCRH  = 120;

   typedef struct {
      int x;
      int y;
      int c;
      int t;
   } pix_t;

   logic       clk = 1'b0;
   logic       resetn [2];
   logic       start [2];
   logic       mode [2];
   logic [7:0] xIn [2];
   logic [6:0] yIn [2];
   logic [2:0] fillColour [2];
   logic [7:0] romAddr [2];
   logic [2:0] romData [2];
   logic [7:0] vgaX [2];
   logic [6:0] vgaY [2];
   logic [2:0] vgaColour [2];
   logic       plot [2];
   logic       busy [2];
   logic       done [2];

   logic [2:0] romMem0 [NPIX];
   logic [2:0] romMem1 [NPIX];
   logic [7:0] pipe1;
   logic [7:0] pipe2;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   pix_t expQ0 [$];
   pix_t expQ1 [$];
   int   doneQ0 [$];
   int   doneQ1 [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   draw_sprite_engine #(.ROM_LAT(LAT0)) dut0 (
      .clk(clk), .resetn(resetn[0]), .start(start[0]), .mode(mode[0]),
      .x_in(xIn[0]), .y_in(yIn[0]), .fill_colour(fillColour[0]),
      .rom_addr(romAddr[0]), .rom_data(romData[0]),
      .vga_x(vgaX[0]), .vga_y(vgaY[0]), .vga_colour(vgaColour[0]),
      .plot(plot[0]), .busy(busy[0]), .done(done[0])
   );

   draw_sprite_engine #(.ROM_LAT(LAT1)) dut1 (
      .clk(clk), .resetn(resetn[1]), .start(start[1]), .mode(mode[1]),
      .x_in(xIn[1]), .y_in(yIn[1]), .fill_colour(fillColour[1]),
      .rom_addr(romAddr[1]), .rom_data(romData[1]),
      .vga_x(vgaX[1]), .vga_y(vgaY[1]), .vga_colour(vgaColour[1]),
      .plot(plot[1]), .busy(busy[1]), .done(done[1])
   );

   // External sprite ROMs: one-cycle and three-cycle read pipelines.
   always @(posedge clk) begin
      romData[0] <= romMem0[romAddr[0]];
      pipe1      <= romAddr[1];
      pipe2      <= pipe1;
      romData[1] <= romMem1[pipe2];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every plot and done pulse is matched against the scoreboard in order.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (plot[i]) begin
            pix_t e;
            int   have;
            have = (i == 0) ? expQ0.size() : expQ1.size();
            if (have == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL dut%0d.unexpectedPlot actual=(%0d,%0d) expected=none (cycle %0d)",
                        i, vgaX[i], vgaY[i], cyc);
            end else begin
               if (i == 0) e = expQ0.pop_front();
               else        e = expQ1.pop_front();
               checkOutput($sformatf("dut%0d.plotX", i), int'(vgaX[i]), e.x);
               checkOutput($sformatf("dut%0d.plotY", i), int'(vgaY[i]), e.y);
               checkOutput($sformatf("dut%0d.plotColour", i), int'(vgaColour[i]), e.c);
               checkOutput($sformatf("dut%0d.plotCycle", i), cyc, e.t);
            end
         end
         if (done[i]) begin
            int dt;
            int have;
            have = (i == 0) ? doneQ0.size() : doneQ1.size();
            if (have == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL dut%0d.unexpectedDone actual=1 expected=0 (cycle %0d)", i, cyc);
            end else begin
               if (i == 0) dt = doneQ0.pop_front();
               else        dt = doneQ1.pop_front();
               checkOutput($sformatf("dut%0d.doneCycle", i), cyc, dt);
               checkOutput($sformatf("dut%0d.busyDuringDone", i), int'(busy[i]), 1);
            end
         end
      end
   end

   // Called on a negedge in IDLE; predicts the whole rectangle, then pulses start for one edge.
   task automatic applyStimulus(input int inst, input bit md, input int x, input int y, input int fc);
      int   base;
      int   lat;
      int   k;
      int   px;
      int   py;
      int   col;
      pix_t p;
      lat  = (inst == 0) ? LAT0 : LAT1;
      base = cyc;
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            k  = r * SW + c;
            px = x + c;
            py = y + r;
            if (md) col = fc;
            else if (inst == 0) col = int'(romMem0[k]);
            else col = int'(romMem1[k]);
            p.x = px;
            p.y = py;
            p.c = col;
            p.t = md ? base + k + 1 : base + (k + 1) * (lat + 1);
            if (px < SCRW && py < SCRH && (md || col != 0)) begin
               if (inst == 0) expQ0.push_back(p);
               else           expQ1.push_back(p);
            end
         end
      end
      if (inst == 0) doneQ0.push_back(md ? base + NPIX + 1 : base + NPIX * (lat + 1) + 1);
      else           doneQ1.push_back(md ? base + NPIX + 1 : base + NPIX * (lat + 1) + 1);
      start[inst]      = 1'b1;
      mode[inst]       = md;
      xIn[inst]        = 8'(x);
      yIn[inst]        = 7'(y);
      fillColour[inst] = 3'(fc);
      @(negedge clk);
      start[inst] = 1'b0;
   endtask

   // Returns on the negedge of the first IDLE cycle after done.
   task automatic waitIdle(input int inst, input int budget);
      int n;
      int pending;
      n = 0;
      pending = (inst == 0) ? doneQ0.size() : doneQ1.size();
      while (pending != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         pending = (inst == 0) ? doneQ0.size() : doneQ1.size();
      end
      if (pending != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d.doneTimeout actual=none expected=done within %0d cycles", inst, budget);
         if (inst == 0) begin expQ0.delete(); doneQ0.delete(); end
         else           begin expQ1.delete(); doneQ1.delete(); end
      end
      @(negedge clk);
      checkOutput($sformatf("dut%0d.busyAfterDone", inst), int'(busy[inst]), 0);
      checkOutput($sformatf("dut%0d.doneAfterDone", inst), int'(done[inst]), 0);
      checkOutput($sformatf("dut%0d.missingPlots", inst), (inst == 0) ? expQ0.size() : expQ1.size(), 0);
   endtask

   task automatic checkIdleOutputs(input int inst, input int ex, input int ey);
      checkOutput($sformatf("dut%0d.idlePlot", inst), int'(plot[inst]), 0);
      checkOutput($sformatf("dut%0d.idleBusy", inst), int'(busy[inst]), 0);
      checkOutput($sformatf("dut%0d.idleDone", inst), int'(done[inst]), 0);
      checkOutput($sformatf("dut%0d.idleRomAddr", inst), int'(romAddr[inst]), 0);
      checkOutput($sformatf("dut%0d.idleVgaX", inst), int'(vgaX[inst]), ex);
      checkOutput($sformatf("dut%0d.idleVgaY", inst), int'(vgaY[inst]), ey);
      checkOutput($sformatf("dut%0d.idleColour", inst), int'(vgaColour[inst]), 0);
   endtask

   task automatic fillRom(input int inst, input int kind);
      for (int k = 0; k < NPIX; k++) begin
         logic [2:0] v;
         v = (kind < 0) ? 3'($urandom_range(0, 7)) : 3'(kind);
         if (inst == 0) romMem0[k] = v;
         else           romMem1[k] = v;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         resetn[i]     = 1'b0;
         start[i]      = 1'b0;
         mode[i]       = 1'b0;
         xIn[i]        = '0;
         yIn[i]        = '0;
         fillColour[i] = '0;
      end
      fillRom(0, 0);
      fillRom(1, 0);
      repeat (3) @(negedge clk);
      checkIdleOutputs(0, 0, 0);
      checkIdleOutputs(1, 0, 0);
      resetn[0] = 1'b1;
      resetn[1] = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] sprite draw, ROM all 5, at (10,20)");
      fillRom(0, 5);
      applyStimulus(0, 1'b0, 10, 20, 0);
      waitIdle(0, 2000);
      checkIdleOutputs(0, 25, 35);

      $display("[TB] transparency: ROM addr 5 is the key colour");
      fillRom(0, 3);
      romMem0[5] = 3'd0;
      applyStimulus(0, 1'b0, 10, 20, 0);
      waitIdle(0, 2000);

      $display("[TB] clipped fill at (150,110)");
      applyStimulus(0, 1'b1, 150, 110, 6);
      waitIdle(0, 2000);

      $display("[TB] start while busy is ignored, back-to-back start accepted");
      fillRom(0, -1);
      applyStimulus(0, 1'b0, 40, 50, 0);
      repeat (98) @(negedge clk);
      start[0] = 1'b1;
      mode[0]  = 1'b1;
      xIn[0]   = 8'd99;
      yIn[0]   = 7'd5;
      @(negedge clk);
      start[0] = 1'b0;
      waitIdle(0, 2000);
      applyStimulus(0, 1'b1, 0, 0, 4);
      waitIdle(0, 2000);

      $display("[TB] reset mid-draw");
      applyStimulus(0, 1'b0, 30, 40, 0);
      repeat (48) @(negedge clk);
      #2;
      resetn[0] = 1'b0;
      #1;
      checkIdleOutputs(0, 0, 0);
      expQ0.delete();
      doneQ0.delete();
      @(negedge clk);
      resetn[0] = 1'b1;
      repeat (20) @(negedge clk);
      applyStimulus(0, 1'b0, 5, 6, 0);
      waitIdle(0, 2000);

      $display("[TB] ROM_LAT=3 fill and sprite");
      applyStimulus(1, 1'b1, 0, 0, 2);
      waitIdle(1, 2000);
      fillRom(1, -1);
      applyStimulus(1, 1'b0, 12, 34, 0);
      waitIdle(1, 2000);

      $display("[TB] random draws");
      for (int n = 0; n < 8; n++) begin
         int inst;
         inst = n % 2;
         fillRom(inst, -1);
         applyStimulus(inst, 1'($urandom_range(0, 1)), int'($urandom_range(0, 200)),
                       int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
         waitIdle(inst, 2000);
      end

      checkOutput("leftoverExpected", expQ0.size() + expQ1.size() + doneQ0.size() + doneQ1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/draw_sprite_engine.md
# draw_sprite_engine

Parametrised sprite/fill renderer that replaces the fixed 16x16 gold and stone drawing FSMs and their per-object datapaths with one self-contained engine. It walks a W x H rectangle in row-major order, reads colour words from an external sprite ROM, and issues one VGA-adapter write per visible pixel. It supports ROM-latency tolerance, colour-key transparency, screen-edge clipping and a solid-fill mode for background and erase work. It sits between the game controller, which issues `start`/`done`, and the VGA adapter write port.

## Interface
- SPRITE_W, 16, sprite width in pixels (>=1)
- SPRITE_H, 16, sprite height in pixels (>=1)
- SCREEN_W, 160, visible screen width; columns >= SCREEN_W are clipped
- SCREEN_H, 120, visible screen height; rows >= SCREEN_H are clipped
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour word width
- ROM_LAT, 1, sprite ROM read latency in cycles (>=1)
- KEY_COLOR, 0, transparent colour key in sprite mode
- ADDR_W, $clog2(SPRITE_W*SPRITE_H), ROM address width (derived)

- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a draw; sampled only in IDLE
- mode  in  1  0 = sprite from ROM, 1 = solid fill; latched on start
- x_in  in  X_W  top-left x; latched on start
- y_in  in  Y_W  top-left y; latched on start
- fill_colour  in  COLOR_W  fill colour; latched on start
- rom_addr  out  ADDR_W  sprite ROM address, row*SPRITE_W+col
- rom_data  in  COLOR_W  ROM output, valid ROM_LAT cycles after rom_addr
- vga_x  out  X_W  pixel x for the write
- vga_y  out  Y_W  pixel y for the write
- vga_colour  out  COLOR_W  pixel colour for the write
- plot  out  1  VGA write enable, one cycle per written pixel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the rectangle is finished

## Operation
- States: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE: on `start`=1, latch x_in, y_in, mode and fill_colour, and clear col/row. Go to FETCH if mode=0, else WRITE. Otherwise stay in IDLE.
- FETCH (sprite only): drive rom_addr for the current col/row for one cycle. Go to WAIT if ROM_LAT>1, else WRITE.
- WAIT: hold rom_addr for ROM_LAT-1 cycles using an internal latency counter, then go to WRITE.
- WRITE: compute px = x_lat+col and py = y_lat+row at widths X_W+1 and Y_W+1, so there is no wrap. Drive vga_x/vga_y with the low bits of px/py. vga_colour = rom_data in sprite mode, fill_colour in fill mode.
- plot = 1 in WRITE only if px<SCREEN_W, py<SCREEN_H and (mode=1 or rom_data!=KEY_COLOR).
- Pixel advance in WRITE: col+1. When col=SPRITE_W-1, col wraps to 0 and row+1.
- After the last pixel (col=SPRITE_W-1, row=SPRITE_H-1) go to DONE. Otherwise go to FETCH (sprite) or stay in WRITE (fill).
- DONE: done=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. Inputs are not re-sampled mid-draw.
- Outputs outside WRITE: plot=0 and vga_colour=0. vga_x/vga_y hold their last values.
- Reset, asynchronous and possible at any point mid-draw: state=IDLE; col, row and latches = 0; plot=0, busy=0, done=0, rom_addr=0, vga_x=0, vga_y=0, vga_colour=0. No further plot until a new start.

## Timing
- Outputs are decoded from registered state and counters. There is no combinational path from start to any output.
- Start accepted at edge 0 puts the block in FETCH (or WRITE in fill mode) at cycle 1.
- Sprite mode: each pixel takes ROM_LAT+1 cycles. The last WRITE is at cycle W*H*(ROM_LAT+1), done is high in the next cycle, and IDLE follows one cycle later.
- Fill mode: one pixel per cycle. The last WRITE is at cycle W*H, followed by done.
- A new start may be accepted in the first IDLE cycle after done. Back-to-back draws therefore have a 2-cycle gap (DONE plus IDLE).
- rom_data is sampled in WRITE, exactly ROM_LAT cycles after rom_addr was first driven.

## Test plan
- Sprite draw, defaults, ROM filled with 3'b101, x=10, y=20 -> 256 plots. First is (10,20), last is (25,35), all colour 5. Plots in cycles 2,4,…,512. done=1 in cycle 513; busy falls at cycle 514.
- Transparency: ROM addr 5 holds 0, all others 3 -> 255 plots, with no write at (15,20).
- Clipping: x=150, y=110, fill mode -> only px<160 and py<120 are written. That is 10x10 = 100 plots; done still arrives after 256 WRITE cycles.
- Fill mode plus ROM_LAT=3 build: fill 3'b010 at (0,0) -> 256 consecutive plot cycles, with no ROM reads needed. A sprite draw in the same build -> rom_data is sampled 3 cycles after each address and each pixel takes 4 cycles.
- Start while busy: pulse start with new x/y at cycle 100 -> ignored, and the original draw completes unchanged. Start again on the IDLE cycle after done -> accepted.
- Reset mid-draw: assert resetn=0 at cycle 50 -> plot, busy, done and rom_addr go to 0 immediately. After release, no plot occurs until the next start, which then draws from pixel (0,0).
